vedic_mul8_seq: RTL
===================

Name: vedic_mul8_seq

Overview:
- Iterative unsigned 8x8 multiplier controller.
- Time-shares one combinational Multiplier4x4 instance over four cycles to produce a 16-bit product.
- Accumulates the four nibble partial products with shifts.
- Sits between an upstream operand source and a downstream consumer, both using valid/ready handshakes. Trades throughput for area against a full 8x8 Vedic tree.

Parameters:
- N, 8, operand width. Fixed at 2x the sub-multiplier width of 4; other values are unsupported.
- H, 4, sub-multiplier operand width (N/2). Local, not overridable.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair A/B valid
- in_ready  output  1  block can accept operands
- A  input  8  multiplicand, unsigned
- B  input  8  multiplier, unsigned
- out_valid  output  1  Product valid
- out_ready  input  1  consumer accepts Product
- Product  output  16  A*B, unsigned
- busy  output  1  high in CALC or DONE

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low, applied via rst_n.
- Reset values (asserted at any time, including mid-operation):
  - state=IDLE, step=0, acc=0, latched A/B=0.
  - out_valid=0, busy=0, Product=0, in_ready=1 once reset deasserts.
  - An in-flight operation is discarded and no output is produced.
- States: IDLE, CALC, DONE. step is a 2-bit counter used only in CALC.
- IDLE:
  - in_ready=1.
  - On the edge where in_valid&&in_ready: latch A/B into a_r/b_r, clear acc, step=0, go to CALC.
- CALC:
  - in_ready=0, busy=1.
  - The Multiplier4x4 inputs are selected by step:
    - step0: a_r[3:0]*b_r[3:0], shift 0
    - step1: a_r[7:4]*b_r[3:0], shift 4
    - step2: a_r[3:0]*b_r[7:4], shift 4
    - step3: a_r[7:4]*b_r[7:4], shift 8
  - Each edge: acc <= acc + (pp << shift), with pp zero-extended to 16 bits. step increments.
  - After the step3 edge, go to DONE.
- Width rule: acc is 16 bits. The maximum result is 0xFE01, so no overflow or carry-out handling is needed.
- DONE:
  - out_valid=1, Product=acc, busy=1, in_ready=0.
  - Product and out_valid hold stable until out_valid&&out_ready.
  - On that edge go to IDLE and deassert out_valid.
- Latency:
  - out_valid rises exactly 4 clk edges after the accepting edge.
  - With out_ready tied high, one operation completes every 6 cycles: accept, 4 CALC, 1 DONE.
- Ignored inputs:
  - in_valid while in_ready=0 is ignored; operands are not captured and there is no error flag.
  - Changes on A/B after acceptance have no effect, because the operand registers are used.
- Backpressure: out_ready low in DONE stalls indefinitely, with Product unchanged.
- Stray out_ready: out_ready asserted outside DONE has no effect.
- No combinational paths:
  - in_ready depends only on state; no path from in_valid.
  - out_valid depends only on state; no path from out_ready.
- Product is driven from acc, is registered, and is meaningful only when out_valid=1.

Test Plan:
- Reset then A=0x12,B=0x34 with in_valid one cycle and out_ready=1 -> out_valid high 4 edges after accept with Product=0x03A8; in_ready returns to 1 the cycle after the output handshake.
- A=0xFF,B=0xFF -> Product=0xFE01 (max case, no overflow); A=0x00,B=0xA5 -> Product=0x0000; A=0x10,B=0x01 -> 0x0010 (checks step1 shift).
- out_ready held low for 10 cycles in DONE -> out_valid stays 1, Product stays constant, in_ready stays 0; then assert out_ready -> exactly one transfer is observed.
- A new in_valid with A=0x0F,B=0x0F asserted during CALC -> ignored, and the running result (e.g. 0x12*0x34=0x03A8) is unaffected; resent in IDLE -> Product=0x00E1.
- Drive rst_n low asynchronously during step2 -> busy, out_valid and Product go to 0 immediately; after release, no stale out_valid appears; the next operation 0x03*0x05 -> 0x000F.
- Back-to-back random operand stream with random out_ready: every accepted pair yields exactly one output equal to A*B, in order, with no drops or duplicates.

Source files
------------

// File: rtl/vedic_mul8_seq.sv
// rtl/vedic_mul8_seq.sv - iterative 8x8 unsigned multiplier sharing one 4x4 Vedic core
// Four CALC cycles accumulate shifted nibble partial products into a 16-bit result.

module vedic_mul2x2 (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic [3:0] p_o
);
  logic t0, t1, t2, c;

  assign t0     = a_i[1] & b_i[0];
  assign t1     = a_i[0] & b_i[1];
  assign t2     = a_i[1] & b_i[1];
  assign c      = t0 & t1;
  assign p_o[0] = a_i[0] & b_i[0];
  assign p_o[1] = t0 ^ t1;
  assign p_o[2] = t2 ^ c;
  assign p_o[3] = t2 & c;
endmodule

module vedic_mul4x4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);
  logic [3:0] q0, q1, q2, q3;

  vedic_mul2x2 u_ll (.a_i(a_i[1:0]), .b_i(b_i[1:0]), .p_o(q0));
  vedic_mul2x2 u_hl (.a_i(a_i[3:2]), .b_i(b_i[1:0]), .p_o(q1));
  vedic_mul2x2 u_lh (.a_i(a_i[1:0]), .b_i(b_i[3:2]), .p_o(q2));
  vedic_mul2x2 u_hh (.a_i(a_i[3:2]), .b_i(b_i[3:2]), .p_o(q3));

  // Cross terms share weight 4; the sum never exceeds 8 bits (max 15*15).
  assign p_o = {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
endmodule

module vedic_mul8_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] Product,
  output logic           busy
);
  localparam int H = N / 2;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q;
  logic [1:0]     step_q;
  logic [N-1:0]   a_q, b_q;
  logic [2*N-1:0] acc_q, acc_d, addend;
  logic [H-1:0]   mul_a, mul_b;
  logic [N-1:0]   pp;
  logic           in_ready_q, out_valid_q, busy_q;

  // step[0] picks the multiplicand nibble, step[1] the multiplier nibble.
  assign mul_a = step_q[0] ? a_q[N-1:H] : a_q[H-1:0];
  assign mul_b = step_q[1] ? b_q[N-1:H] : b_q[H-1:0];

  vedic_mul4x4 u_core (.a_i(mul_a), .b_i(mul_b), .p_o(pp));

  always_comb begin
    addend = '0;
    case (step_q)
      2'd0:    addend = {{N{1'b0}}, pp};
      2'd3:    addend = {pp, {N{1'b0}}};
      default: addend = {{H{1'b0}}, pp, {H{1'b0}}};
    endcase
    acc_d = acc_q + addend;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      step_q      <= 2'd0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= A;
            b_q        <= B;
            acc_q      <= '0;
            step_q     <= 2'd0;
            state_q    <= CALC;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        CALC: begin
          acc_q  <= acc_d;
          step_q <= step_q + 2'd1;
          if (step_q == 2'd3) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign Product   = acc_q;
endmodule
